// File: rtl/puf_crp_ctrl.sv
// Arbiter-PUF challenge/response controller: LFSR challenges, PREP/FIRE launch phases, majority vote of N_VOTES samples.
// Latency: 2*SETTLE*N_VOTES cycles from the first PREP cycle to resp_valid; arb_in passes through a 2-flop synchronizer.
// Backpressure: the response and its challenge are held stable while resp_ready is low; no new evaluation starts until accepted.
module puf_crp_ctrl #(
    parameter int                  N_STAGES = 64,
    parameter logic [N_STAGES-1:0] TAPS     = 64'hD800_0000_0000_0000,
    parameter logic [N_STAGES-1:0] SEED     = 64'h0000_0000_0000_0001,
    parameter int                  SETTLE   = 8,
    parameter int                  N_VOTES  = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [15:0]                      num_crp,
    input  logic                             seed_load,
    input  logic [N_STAGES-1:0]              seed,
    output logic [N_STAGES-1:0]              challenge,
    output logic                             launch,
    input  logic                             arb_in,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic                             resp_bit,
    output logic [$clog2(N_VOTES+1)-1:0]     resp_ones,
    output logic                             busy,
    output logic                             done
);

    localparam int CW = $clog2(N_VOTES + 1);
    localparam int PW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        FIRE = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state;
    logic [PW-1:0]       phase;
    logic [CW-1:0]       vote_cnt;
    logic [CW-1:0]       ones;
    logic [15:0]         crp_cnt;
    logic [15:0]         num_lat;
    logic                arb_s1;
    logic                arb_s2;

    logic [CW-1:0]       ones_next;
    logic [CW-1:0]       vote_next;
    logic [15:0]         crp_next;
    logic [N_STAGES-1:0] lfsr_next;
    logic [N_STAGES-1:0] seed_fix;
    logic                last_phase;

    // Next-value arithmetic shared by the FSM: vote accumulation, LFSR step, seed sanitising.
    always_comb begin
        ones_next  = ones + CW'(arb_s2);
        vote_next  = vote_cnt + CW'(1);
        crp_next   = crp_cnt + 16'd1;
        lfsr_next  = {challenge[N_STAGES-2:0], ^(challenge & TAPS)};
        seed_fix   = (seed == '0) ? N_STAGES'(1) : seed;
        last_phase = (phase == PW'(SETTLE - 1));
    end

    // Single FSM: launch phasing, vote sampling, response handshake and run bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            vote_cnt   <= '0;
            ones       <= '0;
            crp_cnt    <= '0;
            num_lat    <= '0;
            arb_s1     <= 1'b0;
            arb_s2     <= 1'b0;
            challenge  <= SEED;
            launch     <= 1'b0;
            resp_valid <= 1'b0;
            resp_bit   <= 1'b0;
            resp_ones  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // only the second flop is ever consumed; the first may go metastable
            arb_s1 <= arb_in;
            arb_s2 <= arb_s1;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    // a seed load takes priority and swallows a simultaneous start
                    if (seed_load) begin
                        challenge <= seed_fix;
                    end else if (start && (num_crp != 16'd0)) begin
                        num_lat  <= num_crp;
                        crp_cnt  <= '0;
                        vote_cnt <= '0;
                        ones     <= '0;
                        phase    <= '0;
                        busy     <= 1'b1;
                        state    <= PREP;
                    end
                end

                PREP: begin
                    // launch held low so both delay paths fully discharge
                    if (last_phase) begin
                        phase  <= '0;
                        launch <= 1'b1;
                        state  <= FIRE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                FIRE: begin
                    if (last_phase) begin
                        phase    <= '0;
                        launch   <= 1'b0;
                        ones     <= ones_next;
                        vote_cnt <= vote_next;
                        if (vote_next == CW'(N_VOTES)) begin
                            resp_valid <= 1'b1;
                            resp_bit   <= (ones_next > CW'(N_VOTES / 2));
                            resp_ones  <= ones_next;
                            state      <= RESP;
                        end else begin
                            state <= PREP;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                RESP: begin
                    // challenge only advances once its response has been consumed
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        challenge  <= lfsr_next;
                        vote_cnt   <= '0;
                        ones       <= '0;
                        crp_cnt    <= crp_next;
                        if (crp_next == num_lat) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= PREP;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// Bench for puf_crp_ctrl with SETTLE=3, N_VOTES=3: directed runs checked by a response scoreboard.
// Inputs change on the falling edge; the monitor samples one time unit later, away from the rising edge.
// The scoreboard holds challenge/vote expectations computed from vote lists and a reference LFSR.
module tb_puf_crp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_crp = 16'd0;
    logic        seed_load = 1'b0;
    logic [63:0] seed = 64'd0;
    logic [63:0] challenge;
    logic        launch;
    logic        arb_in = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_bit;
    logic [1:0]  resp_ones;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] ch;
        logic        rbit;
        logic [1:0]  ones;
    } exp_t;

    exp_t        exp_q[$];
    int          vote_q[$];
    int          hs_ones_log[$];
    logic [63:0] m_lfsr = 64'h1;
    int          hs_cnt = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    puf_crp_ctrl #(
        .N_STAGES (64),
        .TAPS     (64'hD800_0000_0000_0000),
        .SEED     (64'h0000_0000_0000_0001),
        .SETTLE   (3),
        .N_VOTES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_crp    (num_crp),
        .seed_load  (seed_load),
        .seed       (seed),
        .challenge  (challenge),
        .launch     (launch),
        .arb_in     (arb_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_bit   (resp_bit),
        .resp_ones  (resp_ones),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // x^64+x^63+x^61+x^60+1 written out as explicit bit taps
    function automatic logic [63:0] ref_step(input logic [63:0] x);
        logic fb;
        fb = x[63] ^ x[62] ^ x[60] ^ x[59];
        return {x[62:0], fb};
    endfunction

    // one expected response per CRP: majority of its three votes, paired with the model challenge
    task automatic push_crp(input int v0, input int v1, input int v2);
        exp_t e;
        int   s;
        s      = v0 + v1 + v2;
        e.ch   = m_lfsr;
        e.ones = 2'(s);
        e.rbit = (s >= 2);
        exp_q.push_back(e);
        m_lfsr = ref_step(m_lfsr);
    endtask

    // scoreboard and invariant monitor
    logic        prev_rst = 1'b1;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_bit = 1'b0;
    logic [1:0]  prev_ones = 2'd0;
    logic [63:0] prev_ch = 64'd0;

    always begin
        @(negedge clk);
        #1;
        if (!rst && !prev_rst) begin
            chk("launch_resp_excl", {63'd0, launch & resp_valid}, 64'd0);
            if (resp_valid && resp_ready) begin
                hs_cnt++;
                hs_ones_log.push_back(int'(resp_ones));
                if (exp_q.size() == 0) begin
                    chk("hs_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("hs_challenge", challenge, e.ch);
                    chk("hs_bit", {63'd0, resp_bit}, {63'd0, e.rbit});
                    chk("hs_ones", {62'd0, resp_ones}, {62'd0, e.ones});
                end
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", {63'd0, resp_valid}, 64'd1);
                chk("hold_bit", {63'd0, resp_bit}, {63'd0, prev_bit});
                chk("hold_ones", {62'd0, resp_ones}, {62'd0, prev_ones});
            end
            if (prev_busy && busy && !prev_hs)
                chk("challenge_stable", challenge, prev_ch);
            if (done) begin
                done_cnt++;
                chk("done_busy_low", {63'd0, busy}, 64'd0);
                chk("done_prev_busy", {63'd0, prev_busy}, 64'd1);
            end
        end
        prev_rst   = rst;
        prev_valid = resp_valid;
        prev_ready = resp_ready;
        prev_busy  = busy;
        prev_hs    = resp_valid & resp_ready;
        prev_bit   = resp_bit;
        prev_ones  = resp_ones;
        prev_ch    = challenge;
    end

    // run num CRPs from vote_q (3 votes each); arb_in advances after every launch fall
    task automatic run_votes(input int num, input int budget, input bit poke_start);
        int   idx;
        bit   seen;
        logic prev_l;
        for (int c = 0; c < num; c++)
            push_crp(vote_q[3*c], vote_q[3*c+1], vote_q[3*c+2]);
        idx     = 0;
        arb_in  = vote_q[0][0];
        num_crp = 16'(num);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            prev_l = launch;
            @(negedge clk);
            if (prev_l && !launch) begin
                idx++;
                if (idx < vote_q.size()) arb_in = vote_q[idx][0];
            end
            if (poke_start && k == 10) begin
                start   = 1'b1;
                num_crp = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("run_done_seen", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   h0;
        int   d0;
        bit   found;

        // reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_challenge", challenge, 64'h1);
        chk("rst_launch", {63'd0, launch}, 64'd0);
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        // zero seed becomes 1, single CRP with arb_in tied high, then backpressure
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 64'h0;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed_zero", challenge, 64'h1);
        m_lfsr     = 64'h1;
        arb_in     = 1'b1;
        resp_ready = 1'b0;
        num_crp    = 16'd1;
        push_crp(1, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) chk("busy_first_prep", {63'd0, busy}, 64'd1);
            chk("launch_pat", {63'd0, launch}, (((k - 1) % 6) >= 3) ? 64'd1 : 64'd0);
            chk("valid_early", {63'd0, resp_valid}, 64'd0);
            @(negedge clk);
        end
        chk("lat_valid", {63'd0, resp_valid}, 64'd1);
        chk("lat_bit", {63'd0, resp_bit}, 64'd1);
        chk("lat_ones", {62'd0, resp_ones}, 64'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_challenge", challenge, 64'h1);
            chk("bp_launch", {63'd0, launch}, 64'd0);
            chk("bp_ones", {62'd0, resp_ones}, 64'd3);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("acc_valid", {63'd0, resp_valid}, 64'd0);
        chk("acc_challenge", challenge, 64'h2);
        chk("acc_done", {63'd0, done}, 64'd1);
        chk("acc_busy", {63'd0, busy}, 64'd0);

        // mixed vote patterns, consumer always ready
        vote_q = '{1, 0, 1, 0, 0, 1};
        run_votes(2, 100, 1'b0);
        chk("t3_challenge", challenge, 64'h8);
        chk("t3_ones_a", 64'(hs_ones_log[hs_ones_log.size()-2]), 64'd2);
        chk("t3_ones_b", 64'(hs_ones_log[hs_ones_log.size()-1]), 64'd1);

        // num_crp of zero does not start a run
        @(negedge clk);
        num_crp = 16'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("zero_num_idle", {63'd0, busy}, 64'd0);

        // four CRPs from a loaded seed; a start while busy is ignored
        seed_load = 1'b1;
        seed      = 64'h9000_0000_0000_0001;
        @(negedge clk);
        seed_load = 1'b0;
        chk("t5_seed", challenge, 64'h9000_0000_0000_0001);
        m_lfsr = 64'h9000_0000_0000_0001;
        h0 = hs_cnt;
        d0 = done_cnt;
        vote_q = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        run_votes(4, 200, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_hs_count", 64'(hs_cnt - h0), 64'd4);
        chk("t5_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_final_challenge", challenge, 64'h13);
        chk("t5_model_lfsr", m_lfsr, challenge);

        // reset in the middle of the second CRP's FIRE phase
        arb_in  = 1'b1;
        num_crp = 16'd3;
        push_crp(1, 1, 1);
        push_crp(1, 1, 1);
        h0 = hs_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (hs_cnt > h0 && launch) found = 1'b1;
        end
        chk("t6_reach_fire", {63'd0, found}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_challenge", challenge, 64'h1);
        chk("t6_launch", {63'd0, launch}, 64'd0);
        chk("t6_valid", {63'd0, resp_valid}, 64'd0);
        chk("t6_bit", {63'd0, resp_bit}, 64'd0);
        chk("t6_ones", {62'd0, resp_ones}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        m_lfsr = 64'h1;
        repeat (30) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_hs_count", 64'(hs_cnt - h0), 64'd1);
        chk("t6_idle", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
